// File: rtl/mmcm_drp_sequencer.sv
// ============================================================================
// Module   : mmcm_drp_sequencer
// Summary  : Reconfigures the MMCM at runtime. It holds the MMCM in reset,
//            applies a ROM profile to its DRP registers by read-modify-write,
//            then waits for LOCKED and reports DONE or a coded error.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mmcm_drp_sequencer #(
  parameter int NUM_CFG      = 5,
  parameter int REGS_PER_CFG = 23,
  parameter int ROM_AW       = 7,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CFG_REQ,
  input  logic [2:0]        CFG_SEL,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [1:0]        ERR_CODE,
  output logic [2:0]        CUR_CFG,
  output logic [ROM_AW-1:0] ROM_ADDR,
  input  logic [38:0]       ROM_DATA,
  output logic [6:0]        DADDR,
  output logic [15:0]       DI,
  input  logic [15:0]       DO,
  output logic              DEN,
  output logic              DWE,
  input  logic              DRDY,
  output logic              MMCM_RST,
  input  logic              LOCKED
);

  localparam int          IDX_W     = (REGS_PER_CFG > 1) ? $clog2(REGS_PER_CFG) : 1;
  localparam logic [15:0] DRDY_LIM  = 16'(DRDY_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LIM  = 16'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_RD      = 3'd2,
    S_WAIT_RD = 3'd3,
    S_WR      = 3'd4,
    S_WAIT_WR = 3'd5,
    S_LOCK    = 3'd6,
    S_FAIL    = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       timer_q, timer_d;
  logic [15:0]       mask_q, mask_d;
  logic [15:0]       data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [2:0]        cur_cfg_q, cur_cfg_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [6:0]        daddr_q, daddr_d;
  logic [15:0]       di_q, di_d;
  logic              den_q, den_d;
  logic              dwe_q, dwe_d;
  logic              mmcm_rst_q, mmcm_rst_d;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    timer_d    = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
    mask_d     = mask_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
    cur_cfg_d  = cur_cfg_q;
    rom_addr_d = rom_addr_q;
    daddr_d    = daddr_q;
    di_d       = di_q;
    den_d      = 1'b0;
    dwe_d      = 1'b0;
    mmcm_rst_d = mmcm_rst_q;

    case (state_q)
      S_IDLE: begin
        if (CFG_REQ) begin
          if (32'(CFG_SEL) < NUM_CFG) begin
            sel_d      = CFG_SEL;
            idx_d      = '0;
            busy_d     = 1'b1;
            err_d      = 1'b0;
            err_code_d = 2'd0;
            mmcm_rst_d = 1'b1;
            rom_addr_d = ROM_AW'(32'(CFG_SEL) * REGS_PER_CFG);
            state_d    = S_FETCH;
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end
        end
      end
      // ROM_ADDR was set on the way in; this cycle covers the ROM latency.
      S_FETCH: state_d = S_RD;
      S_RD: begin
        daddr_d = ROM_DATA[38:32];
        mask_d  = ROM_DATA[31:16];
        data_d  = ROM_DATA[15:0];
        den_d   = 1'b1;
        timer_d = '0;
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (DRDY) begin
          di_d    = (DO & mask_q) | (data_q & ~mask_q);
          state_d = S_WR;
        end else if (timer_q >= DRDY_LIM) begin
          state_d    = S_FAIL;
          err_d      = 1'b1;
          err_code_d = 2'd2;
          busy_d     = 1'b0;
          mmcm_rst_d = 1'b0;
        end
      end
      S_WR: begin
        den_d   = 1'b1;
        dwe_d   = 1'b1;
        timer_d = '0;
        state_d = S_WAIT_WR;
      end
      S_WAIT_WR: begin
        if (DRDY) begin
          if (32'(idx_q) == REGS_PER_CFG - 1) begin
            mmcm_rst_d = 1'b0;
            timer_d    = '0;
            state_d    = S_LOCK;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            rom_addr_d = ROM_AW'(32'(sel_q) * REGS_PER_CFG + 32'(idx_q) + 1);
            state_d    = S_FETCH;
          end
        end else if (timer_q >= DRDY_LIM) begin
          state_d    = S_FAIL;
          err_d      = 1'b1;
          err_code_d = 2'd2;
          busy_d     = 1'b0;
          mmcm_rst_d = 1'b0;
        end
      end
      S_LOCK: begin
        if (LOCKED) begin
          done_d    = 1'b1;
          cur_cfg_d = sel_q;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else if (timer_q >= LOCK_LIM) begin
          state_d    = S_FAIL;
          err_d      = 1'b1;
          err_code_d = 2'd3;
          busy_d     = 1'b0;
          mmcm_rst_d = 1'b0;
        end
      end
      // Error flags were raised on entry; the MMCM is left to lock on its own.
      S_FAIL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      cur_cfg_q  <= '0;
      rom_addr_q <= '0;
      daddr_q    <= '0;
      di_q       <= '0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      mmcm_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cur_cfg_q  <= cur_cfg_d;
      rom_addr_q <= rom_addr_d;
      daddr_q    <= daddr_d;
      di_q       <= di_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      mmcm_rst_q <= mmcm_rst_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign ERR_CODE = err_code_q;
  assign CUR_CFG  = cur_cfg_q;
  assign ROM_ADDR = rom_addr_q;
  assign DADDR    = daddr_q;
  assign DI       = di_q;
  assign DEN      = den_q;
  assign DWE      = dwe_q;
  assign MMCM_RST = mmcm_rst_q;

endmodule

`default_nettype wire

// File: tb/tb_mmcm_drp_sequencer.sv
// ============================================================================
// Module   : tb_mmcm_drp_sequencer
// Summary  : Scoreboard bench for mmcm_drp_sequencer with ROM, DRP and MMCM
//            lock models.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mmcm_drp_sequencer;

  localparam int NUM_CFG = 5;
  localparam int REGS    = 23;
  localparam int ROM_AW  = 7;
  localparam int DRDY_TO = 64;
  localparam int LOCK_TO = 200;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CFG_REQ = 1'b0;
  logic [2:0]  CFG_SEL = 3'd0;
  logic        BUSY, DONE, ERR, DEN, DWE, MMCM_RST;
  logic [1:0]  ERR_CODE;
  logic [2:0]  CUR_CFG;
  logic [6:0]  ROM_ADDR;
  logic [38:0] ROM_DATA = '0;
  logic [6:0]  DADDR;
  logic [15:0] DI;
  logic [15:0] DO = '0;
  logic        DRDY = 1'b0;
  logic        LOCKED = 1'b0;

  mmcm_drp_sequencer #(
    .NUM_CFG(NUM_CFG), .REGS_PER_CFG(REGS), .ROM_AW(ROM_AW),
    .DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO)
  ) dut (
    .CLK(CLK), .RST(RST), .CFG_REQ(CFG_REQ), .CFG_SEL(CFG_SEL),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_CODE(ERR_CODE),
    .CUR_CFG(CUR_CFG), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .DADDR(DADDR), .DI(DI), .DO(DO), .DEN(DEN), .DWE(DWE), .DRDY(DRDY),
    .MMCM_RST(MMCM_RST), .LOCKED(LOCKED)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ROM / DRP content functions; record 46 carries the hand-worked RMW case.
  function automatic logic [6:0] daddr_f(input int a);
    return 7'(a * 5 + 3);
  endfunction
  function automatic logic [15:0] mask_f(input int a);
    return (a == 46) ? 16'hFF00 : 16'(a * 16'h1111 ^ 16'h0F0F);
  endfunction
  function automatic logic [15:0] data_f(input int a);
    return (a == 46) ? 16'h1234 : 16'(a * 16'h0707 + 16'h1357);
  endfunction
  function automatic logic [15:0] do_f(input logic [6:0] d);
    return (d == daddr_f(46)) ? 16'hA5A5 : 16'(int'(d) * 16'h0123 + 16'h5A5A);
  endfunction

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] di;
    logic [6:0]  rom;
  } drp_t;

  typedef struct packed {
    logic        is_err;
    logic [1:0]  code;
    logic [2:0]  cfg;
    logic [1:0]  ref_sel;   // 0 none, 1 last DEN, 2 MMCM_RST fall
    logic [15:0] delta;
  } out_t;

  drp_t drp_q[$];
  out_t out_q[$];

  task automatic push_profile(input int sel, input int nfull, input bit extra_read);
    drp_t e;
    int a;
    for (int i = 0; i < nfull + (extra_read ? 1 : 0); i++) begin
      a = sel * REGS + i;
      e.we = 1'b0; e.addr = daddr_f(a); e.di = '0; e.rom = 7'(a);
      drp_q.push_back(e);
      if (i < nfull) begin
        e.we = 1'b1;
        e.di = (do_f(daddr_f(a)) & mask_f(a)) | (data_f(a) & ~mask_f(a));
        drp_q.push_back(e);
      end
    end
  endtask

  task automatic push_out(input bit is_err, input logic [1:0] code, input logic [2:0] cfg,
                          input logic [1:0] rs, input int delta);
    out_t o;
    o.is_err = is_err; o.code = code; o.cfg = cfg; o.ref_sel = rs; o.delta = 16'(delta);
    out_q.push_back(o);
  endtask

  // Synchronous ROM, one cycle of latency.
  always @(posedge CLK)
    ROM_DATA <= {daddr_f(int'(ROM_ADDR)), mask_f(int'(ROM_ADDR)), data_f(int'(ROM_ADDR))};

  // DRP slave: DRDY three cycles after DEN, optionally withheld for one read.
  int          drop_rec = -1;
  int          rd_cnt   = 0;
  int          pend     = 0;
  logic [15:0] resp     = '0;
  always @(negedge CLK) begin
    DRDY = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        DRDY = 1'b1;
        DO   = resp;
      end
    end
    if (DEN) begin
      if (!DWE) begin
        if (rd_cnt != drop_rec) begin
          pend = 3;
          resp = do_f(DADDR);
        end
        rd_cnt++;
      end else begin
        pend = 3;
        resp = 16'h0000;
      end
    end
  end

  // MMCM lock: 100 cycles after reset release unless held off.
  bit lock_hold = 1'b0;
  int lk = 0;
  always @(negedge CLK) begin
    if (MMCM_RST || lock_hold) begin
      LOCKED = 1'b0;
      lk = 0;
    end else if (lk < 100) begin
      lk++;
    end else begin
      LOCKED = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each DEN and on each DONE / ERR rise.
  int   cyc = 0;
  int   last_den_cyc = 0;
  int   rst_fall_cyc = 0;
  int   wr_seen = 0;
  logic prev_err = 1'b0;
  logic prev_mrst = 1'b0;
  always @(negedge CLK) begin
    drp_t e;
    out_t o;
    int   refc;
    cyc++;
    if (DEN) begin
      last_den_cyc = cyc;
      if (drp_q.size() == 0) begin
        chk("den_unexpected", 32'd1, 32'd0);
      end else begin
        e = drp_q.pop_front();
        chk("dwe", 32'(DWE), 32'(e.we));
        chk("daddr", 32'(DADDR), 32'(e.addr));
        if (!e.we) begin
          chk("rom_addr", 32'(ROM_ADDR), 32'(e.rom));
        end else begin
          chk("di", 32'(DI), 32'(e.di));
          wr_seen++;
          if (DADDR == daddr_f(46)) chk("rmw_a534", 32'(DI), 32'h0000A534);
        end
      end
    end
    if (prev_mrst && !MMCM_RST) rst_fall_cyc = cyc;
    if (DONE || (ERR && !prev_err)) begin
      if (out_q.size() == 0) begin
        chk("outcome_unexpected", 32'd1, 32'd0);
      end else begin
        o = out_q.pop_front();
        chk("outcome_is_err", 32'(ERR && !DONE), 32'(o.is_err));
        chk("outcome_busy_low", 32'(BUSY), 32'd0);
        chk("outcome_cur_cfg", 32'(CUR_CFG), 32'(o.cfg));
        chk("outcome_mmcm_rst", 32'(MMCM_RST), 32'd0);
        if (o.is_err) chk("outcome_err_code", 32'(ERR_CODE), 32'(o.code));
        if (o.ref_sel != 2'd0) begin
          refc = (o.ref_sel == 2'd1) ? last_den_cyc : rst_fall_cyc;
          chk("timeout_latency", 32'(cyc - refc), 32'(o.delta));
        end
      end
    end
    prev_err  = ERR;
    prev_mrst = MMCM_RST;
  end

  task automatic req(input logic [2:0] sel);
    @(negedge CLK);
    CFG_SEL = sel;
    CFG_REQ = 1'b1;
    @(negedge CLK);
    CFG_REQ = 1'b0;
  endtask

  task automatic wait_not_busy(input string nm, input int maxc);
    int n = 0;
    while (BUSY && n < maxc) begin
      @(negedge CLK);
      n++;
    end
    if (BUSY) chk(nm, 32'd1, 32'd0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_err_code", 32'(ERR_CODE), 32'd0);
    chk("rst_cur_cfg", 32'(CUR_CFG), 32'd0);
    chk("rst_rom_addr", 32'(ROM_ADDR), 32'd0);
    chk("rst_daddr", 32'(DADDR), 32'd0);
    chk("rst_di", 32'(DI), 32'd0);
    chk("rst_den", 32'(DEN), 32'd0);
    chk("rst_dwe", 32'(DWE), 32'd0);
    chk("rst_mmcm_rst", 32'(MMCM_RST), 32'd0);
  endtask

  initial begin
    bit quiet_bad;
    int n;
    repeat (3) @(negedge CLK);
    check_reset_vals();
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Nominal profile 2: ROM 46..68, RMW at record 46.
    push_profile(2, REGS, 1'b0);
    push_out(1'b0, 2'd0, 3'd2, 2'd0, 0);
    req(3'd2);
    chk("nom_busy_high", 32'(BUSY), 32'd1);
    chk("nom_mmcm_rst_high", 32'(MMCM_RST), 32'd1);
    wait_not_busy("nom_wait_timeout", 3000);

    // Out-of-range select: rejected with code 1, nothing else moves.
    push_out(1'b1, 2'd1, 3'd2, 2'd0, 0);
    req(3'd5);
    quiet_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (BUSY || MMCM_RST || DEN) quiet_bad = 1'b1;
      @(negedge CLK);
    end
    chk("bad_sel_quiet", 32'(quiet_bad), 32'd0);

    // DRDY withheld on the read of record 4.
    rd_cnt   = 0;
    drop_rec = 4;
    push_profile(1, 4, 1'b1);
    push_out(1'b1, 2'd2, 3'd2, 2'd1, DRDY_TO);
    req(3'd1);
    chk("drdy_err_cleared", 32'(ERR), 32'd0);
    wait_not_busy("drdy_wait_timeout", 2000);
    drop_rec = -1;

    // LOCKED never asserts: code 3 after LOCK_TO cycles.
    lock_hold = 1'b1;
    push_profile(3, REGS, 1'b0);
    push_out(1'b1, 2'd3, 3'd2, 2'd2, LOCK_TO);
    req(3'd3);
    wait_not_busy("lock_wait_timeout", 3000);
    lock_hold = 1'b0;

    // Recovery request clears ERR and completes.
    push_profile(4, REGS, 1'b0);
    push_out(1'b0, 2'd0, 3'd4, 2'd0, 0);
    req(3'd4);
    chk("recover_err_cleared", 32'(ERR), 32'd0);
    wait_not_busy("recover_wait_timeout", 3000);

    // Reset during the write of record 10 with a request issued while busy.
    wr_seen = 0;
    push_profile(0, 11, 1'b0);
    req(3'd0);
    repeat (5) @(negedge CLK);
    req(3'd1);
    n = 0;
    while (wr_seen < 11 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk("midrst_reached_rec10", 32'(wr_seen >= 11), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check_reset_vals();
    RST = 1'b0;
    repeat (400) @(negedge CLK);
    chk("midrst_no_second_seq", 32'(BUSY), 32'd0);

    chk("sb_drp_empty", 32'(drp_q.size()), 32'd0);
    chk("sb_out_empty", 32'(out_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
